ux607_pwmcap_core: RTL and testbench

//  PWM capture engine: the receive-side counterpart of the PWM generator. Measures high time and

---
 rtl/ux607_pwmcap_pkg.sv | 18 +
 rtl/ux607_pwmcap_infilt.sv | 66 ++++++
 rtl/ux607_pwmcap_core.sv | 138 +++++++++++++
 tb/tb_ux607_pwmcap_core.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ux607_pwmcap_pkg.sv
// Shared definitions for the PWM capture engine: cfg register bit
// positions and the FSM state encoding.
package ux607_pwmcap_pkg;

    localparam int SCALE_LSB = 0;
    localparam int EN_BIT    = 8;
    localparam int ARM1_BIT  = 9;
    localparam int POL_BIT   = 12;
    localparam int CAP_BIT   = 28;
    localparam int OVF_BIT   = 29;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT1 = 2'd1,
        MEAS  = 2'd2
    } state_t;

endpackage

// File: rtl/ux607_pwmcap_infilt.sv
// Input conditioning for the capture engine: synchronizer, polarity
// inversion, optional glitch filter (PWMCAP_FILTER_EN) and edge detect.
module ux607_pwmcap_infilt #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic pin,
    input  logic pol,
    output logic level,
    output logic rise,
    output logic fall
);

    if (SYNC_STAGES < 2 || FILTER_LEN < 1) begin : g_param_check
        $error("ux607_pwmcap_infilt: need SYNC_STAGES >= 2 and FILTER_LEN >= 1");
    end

    logic [SYNC_STAGES-1:0] sync;
    logic                   pin_s;
    logic                   prev;

    // Metastability synchronizer chain for the asynchronous pin.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) sync <= '0;
        else       sync <= {sync[SYNC_STAGES-2:0], pin};
    end

    assign pin_s = sync[SYNC_STAGES-1] ^ pol;

`ifdef PWMCAP_FILTER_EN
    localparam int FW = $clog2(FILTER_LEN + 1);
    logic [FW-1:0] stable_cnt;
    logic          filt;

    // Filtered level follows pin_s only after FILTER_LEN consecutive differing cycles.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            filt       <= 1'b0;
            stable_cnt <= '0;
        end else if (pin_s == filt) begin
            stable_cnt <= '0;
        end else if (stable_cnt == FW'(FILTER_LEN - 1)) begin
            filt       <= pin_s;
            stable_cnt <= '0;
        end else begin
            stable_cnt <= stable_cnt + 1'b1;
        end
    end

    assign level = filt;
`else
    assign level = pin_s;
`endif

    // One-flop history for edge detection.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) prev <= 1'b0;
        else       prev <= level;
    end

    assign rise = level & ~prev;
    assign fall = ~level & prev;

endmodule

// File: rtl/ux607_pwmcap_core.sv
// PWM capture engine: measures high time and period of io_pin.
// Optional glitch filter enabled with macro PWMCAP_FILTER_EN.
module ux607_pwmcap_core
    import ux607_pwmcap_pkg::*;
#(
    parameter int CNT_W       = 24,
    parameter int CAP_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_pin,
    input  logic        io_regs_cfg_write_valid,
    input  logic [31:0] io_regs_cfg_write_bits,
    output logic [31:0] io_regs_cfg_read,
    output logic [31:0] io_regs_count_read,
    output logic [31:0] io_regs_high_read,
    output logic [31:0] io_regs_period_read,
    output logic        io_ip_0,
    output logic        io_ip_1
);

    state_t           state, state_nxt;
    logic [3:0]       scale;
    logic             en, arm1, pol, cap, ovf;
    logic [CNT_W-1:0] raw, scaled;
    logic [CAP_W-1:0] sat, hi_lat, high, period;
    logic             level, rise, fall;
    logic             over, en_eff, capture, ovf_hit;
    logic             wr;
    logic [31:0]      wd;
    logic             unused_bits;

    assign wr = io_regs_cfg_write_valid;
    assign wd = io_regs_cfg_write_bits;
    assign unused_bits = ^{level, wd[31:30], wd[27:13], wd[11:10], wd[7:4]};

    ux607_pwmcap_infilt #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_infilt (
        .clock (clock),
        .reset (reset),
        .pin   (io_pin),
        .pol   (pol),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    // Prescale and saturation; a cfg write takes effect on enable at the same edge.
    always_comb begin
        scaled  = raw >> scale;
        over    = |scaled[CNT_W-1:CAP_W];
        sat     = over ? '1 : scaled[CAP_W-1:0];
        en_eff  = wr ? wd[EN_BIT] : en;
        capture = (state == MEAS) && rise;
        ovf_hit = (state == MEAS) && !rise && over;
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en_eff) state_nxt = WAIT1;
            WAIT1:   if (!en_eff) state_nxt = IDLE;
                     else if (rise) state_nxt = MEAS;
            MEAS:    if (!en_eff) state_nxt = IDLE;
                     else if (capture && arm1) state_nxt = IDLE;
                     else if (ovf_hit) state_nxt = WAIT1;
            default: state_nxt = IDLE;
        endcase
    end

    // Counter, capture registers and cfg; software writes beat hardware sets.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            raw    <= '0;
            hi_lat <= '0;
            high   <= '0;
            period <= '0;
            scale  <= '0;
            en     <= 1'b0;
            arm1   <= 1'b0;
            pol    <= 1'b0;
            cap    <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            if (state_nxt != MEAS)              raw <= '0;
            else if (state != MEAS || capture)  raw <= CNT_W'(1);
            else if (raw != '1)                 raw <= raw + 1'b1;

            if (state == MEAS && fall) hi_lat <= sat;
            if (capture) begin
                period <= sat;
                high   <= hi_lat;
            end

            if (wr) begin
                scale <= wd[SCALE_LSB +: 4];
                en    <= wd[EN_BIT];
                arm1  <= wd[ARM1_BIT];
                pol   <= wd[POL_BIT];
                cap   <= wd[CAP_BIT];
                ovf   <= wd[OVF_BIT];
            end else begin
                if (capture)         cap <= 1'b1;
                if (capture && arm1) en  <= 1'b0;
                if (ovf_hit)         ovf <= 1'b1;
            end
        end
    end

    // Register read mux.
    always_comb begin
        io_regs_cfg_read                    = '0;
        io_regs_cfg_read[SCALE_LSB +: 4]    = scale;
        io_regs_cfg_read[EN_BIT]            = en;
        io_regs_cfg_read[ARM1_BIT]          = arm1;
        io_regs_cfg_read[POL_BIT]           = pol;
        io_regs_cfg_read[CAP_BIT]           = cap;
        io_regs_cfg_read[OVF_BIT]           = ovf;
        io_regs_count_read                  = 32'(raw);
        io_regs_high_read                   = 32'(high);
        io_regs_period_read                 = 32'(period);
    end

    assign io_ip_0 = cap;
    assign io_ip_1 = ovf;

endmodule

// File: tb/tb_ux607_pwmcap_core.sv
// Self-checking bench for ux607_pwmcap_core; honours PWMCAP_FILTER_EN.
module tb_ux607_pwmcap_core;

    localparam int SYNC_STAGES = 2;
    localparam int FILTER_LEN  = 4;
`ifdef PWMCAP_FILTER_EN
    localparam int LAT = SYNC_STAGES + 1 + FILTER_LEN;
`else
    localparam int LAT = SYNC_STAGES + 1;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        pin   = 1'b0;
    logic        wv    = 1'b0;
    logic [31:0] wb    = '0;
    logic [31:0] cfg_rd, cnt_rd, high_rd, per_rd;
    logic        ip0, ip1;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    ux607_pwmcap_core #(
        .CNT_W       (24),
        .CAP_W       (16),
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) dut (
        .clock                   (clock),
        .reset                   (reset),
        .io_pin                  (pin),
        .io_regs_cfg_write_valid (wv),
        .io_regs_cfg_write_bits  (wb),
        .io_regs_cfg_read        (cfg_rd),
        .io_regs_count_read      (cnt_rd),
        .io_regs_high_read       (high_rd),
        .io_regs_period_read     (per_rd),
        .io_ip_0                 (ip0),
        .io_ip_1                 (ip1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wr(input logic [31:0] d);
        wv = 1'b1;
        wb = d;
        @(negedge clock);
        wv = 1'b0;
        wb = '0;
    endtask

    task automatic run_period(input int h, input int l);
        pin = 1'b1;
        cyc(h);
        pin = 1'b0;
        cyc(l);
    endtask

    function automatic logic [31:0] cfgw(input int sc, input bit en, input bit arm1,
                                         input bit pol, input bit cap, input bit ovf);
        logic [31:0] w;
        w = '0;
        w[3:0] = sc[3:0];
        w[8]   = en;
        w[9]   = arm1;
        w[12]  = pol;
        w[28]  = cap;
        w[29]  = ovf;
        return w;
    endfunction

    // Reference: a duration in input cycles, prescaled and clamped to CAP_W bits.
    function automatic int model(input int d, input int sc);
        int v;
        v = d >> sc;
        return (v > 65535) ? 65535 : v;
    endfunction

    initial begin
        int n;
        int sc;
        int hs [8];
        int ls [8];

        // Reset state
        cyc(2);
        check("rst_cfg", cfg_rd, 0);
        check("rst_count", cnt_rd, 0);
        check("rst_ip", {30'd0, ip1, ip0}, 0);
        reset = 1'b0;
        cyc(1);
        check("post_rst_period", per_rd, 0);

        // Overflow with pin held high after the first rise
        wr(cfgw(0, 1, 0, 0, 0, 0));
        cyc(5);
        pin = 1'b1;
        n = 0;
        while (ip1 !== 1'b1 && n < 70000) begin
            @(negedge clock);
            n++;
        end
        check("ovf_latency", n, 65536 + LAT);
        check("ovf_cfg", cfg_rd, cfgw(0, 1, 0, 0, 0, 1));
        check("ovf_count_wait1", cnt_rd, 0);
        check("ovf_period_kept", per_rd, 0);
        wr(cfgw(0, 1, 0, 0, 0, 0));
        cyc(10);
        check("ovf_once", ip1, 0);
        pin = 1'b0;
        cyc(10);
        run_period(30, 70);
        check("wait1_no_capture", per_rd, 0);
        check("wait1_no_cap", ip0, 0);
        run_period(30, 70);
        check("after_ovf_period", per_rd, 100);
        check("after_ovf_high", high_rd, 30);
        wr(0);
        check("disable_count", cnt_rd, 0);

        // Prescale by 4, then clear capture-pending by write
        wr(cfgw(2, 1, 0, 0, 0, 0));
        repeat (3) run_period(30, 70);
        check("scale2_period", per_rd, 25);
        check("scale2_high", high_rd, 7);
        check("scale2_ip0", ip0, 1);
        wr(cfgw(2, 1, 0, 0, 0, 0));
        check("cap_clear", ip0, 0);
        wr(0);

        // Randomized periods against the duration model
        for (int b = 0; b < 3; b++) begin
            sc = $urandom_range(0, 3);
            wr(cfgw(sc, 1, 0, 0, 0, 0));
            for (int j = 0; j < 8; j++) begin
                hs[j] = $urandom_range(6, 60);
                ls[j] = $urandom_range(6, 60);
                run_period(hs[j], ls[j]);
                if (j == 0) begin
                    check("rnd_first_no_cap", ip0, 0);
                end else begin
                    check("rnd_period", per_rd, model(hs[j-1] + ls[j-1], sc));
                    check("rnd_high", high_rd, model(hs[j-1], sc));
                    check("rnd_ip0", ip0, 1);
                end
            end
            wr(0);
        end

        // One-shot arm
        wr(cfgw(0, 1, 1, 0, 0, 0));
        run_period(30, 70);
        run_period(30, 70);
        check("arm1_period", per_rd, 100);
        check("arm1_high", high_rd, 30);
        check("arm1_cfg", cfg_rd, cfgw(0, 0, 1, 0, 1, 0));
        run_period(40, 40);
        run_period(40, 40);
        check("arm1_frozen", per_rd, 100);
        wr(0);

        // Inverted polarity
        wr(cfgw(0, 0, 0, 1, 0, 0));
        cyc(5);
        wr(cfgw(0, 1, 0, 1, 0, 0));
        repeat (3) run_period(30, 70);
        check("pol_high", high_rd, 70);
        check("pol_period", per_rd, 100);
        check("pol_cfg", cfg_rd, cfgw(0, 1, 0, 1, 1, 0));
        wr(0);
        cyc(5);

        // Short glitch in the low phase
        wr(cfgw(0, 1, 0, 0, 0, 0));
        run_period(30, 70);
        run_period(30, 70);
        pin = 1'b1; cyc(30);
        pin = 1'b0; cyc(20);
        pin = 1'b1; cyc(2);
        pin = 1'b0; cyc(48);
`ifdef PWMCAP_FILTER_EN
        check("glitch_period", per_rd, 100);
`else
        check("glitch_period", per_rd, 50);
`endif
        check("glitch_high", high_rd, 30);
        wr(0);

        // Live counter, then asynchronous reset mid-measurement
        wr(cfgw(0, 1, 0, 0, 0, 0));
        run_period(30, 70);
        pin = 1'b1;
        cyc(10);
        check("live_count", cnt_rd, 11 - LAT);
        reset = 1'b1;
        #1;
        check("rst_mid_cfg", cfg_rd, 0);
        check("rst_mid_count", cnt_rd, 0);
        check("rst_mid_high", high_rd, 0);
        check("rst_mid_period", per_rd, 0);
        check("rst_mid_ip", {30'd0, ip1, ip0}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
